// File: rtl/hazard_stall_controller_if.sv
// Hazard/sequencing bus between the pipeline datapath (master) and the stall controller (slave).
// Grouped so the controller's ID/EX observations and its stall/flush controls travel together.
interface hazard_stall_controller_if #(
    parameter int unsigned MD_CNT_W = 6
);
    logic [4:0]          idRs;
    logic [4:0]          idRt;
    logic                idUsesRs;
    logic                idUsesRt;
    logic                idUsesHiLo;
    logic                exMemRead;
    logic [4:0]          exRd;
    logic                mdStart;
    logic                jumpRequest;
    logic                stallID;
    logic                stallEX;
    logic                flushIFID;
    logic                flushIDEX;
    logic                jumpEnabled;
    logic                mdBusy;
    logic [MD_CNT_W-1:0] mdCount;

    modport master (
        output idRs, idRt, idUsesRs, idUsesRt, idUsesHiLo, exMemRead, exRd, mdStart, jumpRequest,
        input  stallID, stallEX, flushIFID, flushIDEX, jumpEnabled, mdBusy, mdCount
    );

    modport slave (
        input  idRs, idRt, idUsesRs, idUsesRt, idUsesHiLo, exMemRead, exRd, mdStart, jumpRequest,
        output stallID, stallEX, flushIFID, flushIDEX, jumpEnabled, mdBusy, mdCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / HI-LO / mult-div hazard and redirect controller for the 5-stage MIPS pipeline.
// Optional stall/flush event counters are enabled by defining HAZARD_PERF_EN.
module hazard_stall_controller #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned MD_CNT_W   = 6
) (
    input logic                      clock,
    input logic                      reset,
    hazard_stall_controller_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]              loadUseStallCnt,
    output logic [31:0]              hiloStallCnt,
    output logic [31:0]              mdStallCnt,
    output logic [31:0]              flushCnt
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_next;
    logic [MD_CNT_W-1:0] count, count_next;
    logic                busy;
    logic                load_use;
    logic                hilo;
    logic                stall_ex;
    logic                jump_en;
    logic                hazard_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (bus.mdStart) begin
                    state_next = BUSY;
                    count_next = MD_CNT_W'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                // A start arriving on the last busy cycle is stalled, not reloaded.
                if (count == '0) state_next = IDLE;
                else             count_next = count - 1'b1;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase

        busy         = (state == BUSY);
        load_use     = bus.exMemRead && (bus.exRd != 5'd0) &&
                       ((bus.idUsesRs && (bus.idRs == bus.exRd)) ||
                        (bus.idUsesRt && (bus.idRt == bus.exRd)));
        hilo         = busy && bus.idUsesHiLo;
        stall_ex     = !reset && bus.mdStart && busy;
        jump_en      = !reset && bus.jumpRequest && !stall_ex;
        hazard_stall = !reset && !stall_ex && !jump_en && (load_use || hilo);

        bus.stallEX     = stall_ex;
        bus.jumpEnabled = jump_en;
        bus.stallID     = hazard_stall;
        bus.flushIFID   = jump_en;
        bus.flushIDEX   = jump_en || hazard_stall;
        bus.mdBusy      = !reset && busy;
        bus.mdCount     = reset ? '0 : count;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            loadUseStallCnt <= '0;
            hiloStallCnt    <= '0;
            mdStallCnt      <= '0;
            flushCnt        <= '0;
        end else begin
            if (hazard_stall && load_use && (loadUseStallCnt != '1)) loadUseStallCnt <= loadUseStallCnt + 1'b1;
            if (hazard_stall && hilo && (hiloStallCnt != '1))        hiloStallCnt    <= hiloStallCnt + 1'b1;
            if (stall_ex && (mdStallCnt != '1))                      mdStallCnt      <= mdStallCnt + 1'b1;
            if (jump_en && (flushCnt != '1))                         flushCnt        <= flushCnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, hand-written mult/div sequences and a randomized run.
module tb_hazard_stall_controller;
    localparam int LAT = 4;
    localparam int CW  = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_stall_controller_if #(.MD_CNT_W(CW)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_cnt, hl_cnt, md_cnt, fl_cnt;
`endif

    hazard_stall_controller #(.MD_LATENCY(LAT), .MD_CNT_W(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
`ifdef HAZARD_PERF_EN
        ,
        .loadUseStallCnt(lu_cnt),
        .hiloStallCnt   (hl_cnt),
        .mdStallCnt     (md_cnt),
        .flushCnt       (fl_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int rem   = 0;   // remaining busy cycles of the modelled mult/div unit

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs, rt;
        logic       ur, ut, uh, jr;
        logic [3:0] exp;   // {stallID, flushIFID, flushIDEX, jumpEnabled}
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic ut, input logic uh, input logic ms, input logic jr);
        bus.exMemRead   = mr;
        bus.exRd        = rd;
        bus.idRs        = rs;
        bus.idRt        = rt;
        bus.idUsesRs    = ur;
        bus.idUsesRt    = ut;
        bus.idUsesHiLo  = uh;
        bus.mdStart     = ms;
        bus.jumpRequest = jr;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset)             rem = 0;
        else if (rem > 0)      rem = rem - 1;
        else if (bus.mdStart)  rem = LAT;
        @(negedge clock);
    endtask

    function automatic logic [5:0] model_flags();
        logic busy, lu, hl, sex, jen, sid;
        busy = !reset && (rem > 0);
        lu   = bus.exMemRead && (bus.exRd != 0) &&
               ((bus.idUsesRs && bus.idRs == bus.exRd) || (bus.idUsesRt && bus.idRt == bus.exRd));
        hl   = busy && bus.idUsesHiLo;
        sex  = busy && bus.mdStart;
        jen  = !reset && bus.jumpRequest && !sex;
        sid  = !reset && !sex && !jen && (lu || hl);
        return {sid, sex, jen, jen || sid, jen, busy};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {bus.stallID, bus.stallEX, bus.flushIFID, bus.flushIDEX, bus.jumpEnabled, bus.mdBusy};
    endfunction

    function automatic logic [3:0] dut_front();
        return {bus.stallID, bus.flushIFID, bus.flushIDEX, bus.jumpEnabled};
    endfunction

    initial begin
        //            mr   rd     rs     rt     ur ut uh jr   exp
        tbl[0] = '{1'b1, 5'd8,  5'd8,  5'd1,  1, 0, 0, 0, 4'b1010};
        tbl[1] = '{1'b1, 5'd0,  5'd0,  5'd1,  1, 0, 0, 0, 4'b0000};
        tbl[2] = '{1'b1, 5'd12, 5'd3,  5'd12, 0, 1, 0, 0, 4'b1010};
        tbl[3] = '{1'b1, 5'd12, 5'd3,  5'd12, 1, 0, 0, 0, 4'b0000};
        tbl[4] = '{1'b0, 5'd8,  5'd8,  5'd8,  1, 1, 0, 0, 4'b0000};
        tbl[5] = '{1'b1, 5'd8,  5'd8,  5'd1,  1, 0, 0, 1, 4'b0111};
        tbl[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 4'b0111};
        tbl[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 4'b0000};

        // Reset holds every output low even with hazards and a redirect presented.
        set_in(1, 8, 8, 8, 1, 1, 1, 1, 1);
        step();
        #1;
        check("reset_flags", {26'd0, dut_flags()}, 32'd0);
        check("reset_count", {26'd0, bus.mdCount}, 32'd0);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        foreach (tbl[i]) begin
            set_in(tbl[i].mr, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].ut, tbl[i].uh, 1'b0, tbl[i].jr);
            #1;
            check($sformatf("tbl%0d", i), {28'd0, dut_front()}, {28'd0, tbl[i].exp});
            check($sformatf("tbl%0d_sex", i), {31'd0, bus.stallEX}, 32'd0);
            step();
        end

        // Single mult/div with HI/LO readers waiting behind it.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 check("md_issue_busy", {31'd0, bus.mdBusy}, 32'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < LAT; i++) begin
            #1;
            check($sformatf("md_busy%0d", i), {31'd0, bus.mdBusy}, 32'd1);
            check($sformatf("md_count%0d", i), {26'd0, bus.mdCount}, 32'(LAT - 1 - i));
            check($sformatf("md_hilo%0d", i), {28'd0, dut_front()}, 32'b1010);
            step();
        end
        #1;
        check("md_done_busy", {31'd0, bus.mdBusy}, 32'd0);
        check("md_done_hilo", {28'd0, dut_front()}, 32'd0);

        // Back-to-back mult/div: second op waits out the whole busy window.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 check("b2b_first", {31'd0, bus.stallEX}, 32'd0);
        step();
        for (int i = 0; i < LAT; i++) begin
            #1;
            check($sformatf("b2b_sex%0d", i), {31'd0, bus.stallEX}, 32'd1);
            check($sformatf("b2b_cnt%0d", i), {26'd0, bus.mdCount}, 32'(LAT - 1 - i));
            step();
        end
        #1 check("b2b_accept", {31'd0, bus.stallEX}, 32'd0);
        step();
        #1;
        check("b2b_reload", {26'd0, bus.mdCount}, 32'(LAT - 1));
        check("b2b_busy2", {31'd0, bus.mdBusy}, 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10 && rem != 0; k++) step();

        // Redirect held back while EX is stalled by a second mult/div.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < LAT; i++) begin
            #1 check($sformatf("jsex%0d", i), {28'd0, dut_front()}, 32'd0);
            step();
        end
        #1 check("jsex_release", {28'd0, dut_front()}, 32'b0111);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10 && rem != 0; k++) step();

        // Reset while the unit is busy with two cycles left.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1 check("rst_mid_cnt", {26'd0, bus.mdCount}, 32'd2);
        reset = 1'b1;
        set_in(1, 8, 8, 0, 1, 0, 1, 1, 1);
        #1 check("rst_mid_forced", {26'd0, dut_flags()}, 32'd0);
        step();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_mid_flags", {26'd0, dut_flags()}, 32'd0);
        check("rst_mid_count", {26'd0, bus.mdCount}, 32'd0);

`ifdef HAZARD_PERF_EN
        set_in(1, 8, 8, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("perf_lu", lu_cnt, 32'd3);
        check("perf_hl", hl_cnt, 32'd0);
        check("perf_fl", fl_cnt, 32'd1);
`endif

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            #1;
            check($sformatf("rnd%0d_flags", n), {26'd0, dut_flags()}, {26'd0, model_flags()});
            check($sformatf("rnd%0d_cnt", n), {26'd0, bus.mdCount},
                  (!reset && rem > 0) ? 32'(rem - 1) : 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
